vga_pattern_gen: RTL and testbench
==================================

# vga_pattern_gen

Parametrised VGA timing and test-pattern generator, successor to the fixed 640x480 gradient generator. It produces registered sync, blank and RGB for any display mode set by parameters. It offers four run-time-selectable patterns, switched cleanly only at frame boundaries, plus pixel-position and frame/line strobes for downstream overlay logic. It sits between the pixel-clock domain and the DVI/TMDS encoder.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync, back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch/sync (lines)
- H_SYNC_POL / V_SYNC_POL, 0 / 0, active level of hSync / vSync
- CNT_W, 12, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- COLOR_W, 8, bits per colour channel
- BAR_W, 80, colour-bar width in pixels
- CHECK_LOG2, 5, checker square size = 2^CHECK_LOG2
- pixelClock  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- mode  in  2  pattern select: 0 gradient, 1 colour bars, 2 checker, 3 solid
- solid_rgb  in  3*COLOR_W  {R,G,B} colour for mode 3
- Red / Green / Blue  out  COLOR_W each  pixel colour
- hSync / vSync  out  1  sync outputs
- blank  out  1  high outside the active area
- hPos / vPos  out  CNT_W  position of the pixel currently on the outputs
- frameStart  out  1  one-cycle pulse with pixel (0,0)
- lineStart  out  1  one-cycle pulse with hPos==0 on every line, including blanked lines

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- hCnt increments each cycle and wraps H_TOTAL-1 -> 0. vCnt increments on the hCnt wrap and wraps V_TOTAL-1 -> 0.
- hSync is active while H_ACTIVE+H_FP <= hCnt < H_ACTIVE+H_FP+H_SYNC. vSync is active while V_ACTIVE+V_FP <= vCnt < V_ACTIVE+V_FP+V_SYNC, changing only at line starts. Otherwise both are inactive.
- blank = !(hCnt < H_ACTIVE && vCnt < V_ACTIVE). While blank is high, RGB = 0.
- Active pattern is held in register curMode. curMode loads from mode during reset and when hCnt==H_TOTAL-1 && vCnt==V_TOTAL-1. A mode change mid-frame takes effect at the next frame.
- Mode 0, gradient: R = hCnt[COLOR_W-1:0], G = vCnt[COLOR_W-1:0], B = (hCnt+vCnt)[COLOR_W-1:0], truncated.
- Mode 1, colour bars:
  - A bar-pixel counter and a 3-bit bar index i both clear at hCnt==0. The index advances every BAR_W pixels and saturates at 7.
  - R = all-ones if !i[1], G = all-ones if !i[2], B = all-ones if !i[0], else 0.
  - Order: white, yellow, cyan, green, magenta, red, blue, black.
  - Pixels beyond 8*BAR_W stay black.
- Mode 2, checker: all channels all-ones when hCnt[CHECK_LOG2]^vCnt[CHECK_LOG2] = 1, else 0.
- Mode 3, solid: RGB = solid_rgb.

## Timing
- Every output is registered from the current counters: latency 1 cycle from counter state to pins. hPos/vPos equal the counter values that produced the RGB on the same cycle.
- Reset values:
  - hCnt = vCnt = 0, RGB = 0, blank = 1.
  - hSync = !H_SYNC_POL, vSync = !V_SYNC_POL (inactive, not 0).
  - hPos = vPos = 0, frameStart = lineStart = 0.
- First cycle after reset deasserts: outputs show the registered reset values. Second cycle: pixel (0,0) appears with frameStart=1 and lineStart=1.
- Reset asserted mid-frame clears all state on the next edge. No partial-line completion.
- Line period is exactly H_TOTAL cycles; frame period is exactly H_TOTAL*V_TOTAL cycles.

## Structure
- Shared package vga_pkg holds:
  - mode encodings MODE_GRADIENT, MODE_BARS, MODE_CHECK, MODE_SOLID
  - VGA_640x480 and VGA_800x600 timing constant sets
- Sub-module vga_timing_core contains the counters, sync/blank decode, strobes and frame-end flag. vga_pattern_gen adds mode latch, bar counter and colour mux.

## Test plan
- Small mode: H 8/2/3/3 (total 16), V 4/1/2/1 (total 8), sync pol 0.
  - Reset released: blank=1, hSync=vSync=1, RGB=0.
  - frameStart every 128 cycles; lineStart every 16.
- hSync timing: low for exactly 3 cycles with hPos 10..12; vSync low for lines 5..6 (32 cycles); blank low only for hPos<8 && vPos<4.
- Mode 1, BAR_W=1, H_ACTIVE=8: RGB per pixel = white, yellow, cyan, green, magenta, red, blue, black (all-ones / 0 channels).
- Mode switches from 0 to 3 at vPos=2: gradient continues to frame end; solid_rgb=0x123456 appears from the next frameStart.
- Mode 2, CHECK_LOG2=1: pixel (0,0) is black, (2,0) white, (2,2) black.
- Reset pulsed at hPos=5, vPos=2: outputs return to reset values. frameStart fires 2 cycles after reset deasserts.

Source files
------------

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA timing / test-pattern generator:
//   - pattern mode encodings (value of the 2-bit mode input)
//   - timing constant sets for common display modes
//   - a small helper to compute a line/frame total from its four segments
// -----------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_GRADIENT = 2'd0,
        MODE_BARS     = 2'd1,
        MODE_CHECK    = 2'd2,
        MODE_SOLID    = 2'd3
    } mode_e;

    // One display mode's timing. Polarity fields give the active sync level.
    typedef struct packed {
        int   h_active;
        int   h_fp;
        int   h_sync;
        int   h_bp;
        int   v_active;
        int   v_fp;
        int   v_sync;
        int   v_bp;
        logic h_pol;
        logic v_pol;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480 = '{
        h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
        h_pol: 1'b0,   v_pol: 1'b0
    };

    localparam vga_timing_t VGA_800x600 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
        h_pol: 1'b1,   v_pol: 1'b1
    };

    function automatic int seg_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_core.sv
// -----------------------------------------------------------------------------
// vga_timing_core
// Horizontal/vertical pixel counters plus registered sync, blank, position and
// frame/line strobes. Also exposes the raw counters and combinational
// active / line-end / frame-end flags so the parent can register colour data
// with the same one-cycle latency as the timing outputs.
//
// Ports:
//   i_clk, i_reset      pixel clock, synchronous active-high reset
//   o_hCnt, o_vCnt      raw counters (combinational view of current state)
//   o_active            counters are inside the visible area
//   o_lineEnd           hCnt is at the last pixel of the line
//   o_frameEnd          counters are at the last pixel of the frame
//   o_hSync, o_vSync    registered sync outputs (polarity per parameter)
//   o_blank             registered, high outside the visible area
//   o_hPos, o_vPos      registered copy of the counters
//   o_frameStart        registered pulse with pixel (0,0)
//   o_lineStart         registered pulse with hPos==0 on every line
// -----------------------------------------------------------------------------
module vga_timing_core #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0,
    parameter int   CNT_W      = 12
) (
    input  logic             i_clk,
    input  logic             i_reset,
    output logic [CNT_W-1:0] o_hCnt,
    output logic [CNT_W-1:0] o_vCnt,
    output logic             o_active,
    output logic             o_lineEnd,
    output logic             o_frameEnd,
    output logic             o_hSync,
    output logic             o_vSync,
    output logic             o_blank,
    output logic [CNT_W-1:0] o_hPos,
    output logic [CNT_W-1:0] o_vPos,
    output logic             o_frameStart,
    output logic             o_lineStart
);
    import vga_pkg::*;

    localparam int H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] r_hCnt, r_vCnt;
    logic [CNT_W-1:0] r_hPos, r_vPos;
    logic             r_hSync, r_vSync, r_blank, r_frameStart, r_lineStart;

    logic w_lineEnd, w_frameEnd, w_active, w_hsAct, w_vsAct;

    assign w_lineEnd  = (r_hCnt == H_LAST);
    assign w_frameEnd = w_lineEnd && (r_vCnt == V_LAST);
    assign w_active   = (r_hCnt < H_VIS) && (r_vCnt < V_VIS);
    assign w_hsAct    = (r_hCnt >= HS_BEG) && (r_hCnt < HS_END);
    // vCnt only moves on the hCnt wrap, so vSync naturally changes at line starts.
    assign w_vsAct    = (r_vCnt >= VS_BEG) && (r_vCnt < VS_END);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hCnt <= '0;
            r_vCnt <= '0;
        end else if (w_lineEnd) begin
            r_hCnt <= '0;
            r_vCnt <= (r_vCnt == V_LAST) ? '0 : r_vCnt + 1'b1;
        end else begin
            r_hCnt <= r_hCnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hSync      <= ~H_SYNC_POL;
            r_vSync      <= ~V_SYNC_POL;
            r_blank      <= 1'b1;
            r_hPos       <= '0;
            r_vPos       <= '0;
            r_frameStart <= 1'b0;
            r_lineStart  <= 1'b0;
        end else begin
            r_hSync      <= w_hsAct ? H_SYNC_POL : ~H_SYNC_POL;
            r_vSync      <= w_vsAct ? V_SYNC_POL : ~V_SYNC_POL;
            r_blank      <= ~w_active;
            r_hPos       <= r_hCnt;
            r_vPos       <= r_vCnt;
            r_frameStart <= (r_hCnt == '0) && (r_vCnt == '0);
            r_lineStart  <= (r_hCnt == '0);
        end
    end

    assign o_hCnt       = r_hCnt;
    assign o_vCnt       = r_vCnt;
    assign o_active     = w_active;
    assign o_lineEnd    = w_lineEnd;
    assign o_frameEnd   = w_frameEnd;
    assign o_hSync      = r_hSync;
    assign o_vSync      = r_vSync;
    assign o_blank      = r_blank;
    assign o_hPos       = r_hPos;
    assign o_vPos       = r_vPos;
    assign o_frameStart = r_frameStart;
    assign o_lineStart  = r_lineStart;

endmodule

// File: rtl/vga_pattern_gen.sv
// -----------------------------------------------------------------------------
// vga_pattern_gen
// Parametrised VGA timing and test-pattern generator. Wraps vga_timing_core
// and adds the frame-synchronous pattern latch, colour-bar counter and colour
// mux. All outputs are registered with one cycle of latency from the counters.
//
// Ports:
//   pixelClock          pixel clock
//   reset               synchronous active-high reset
//   mode[1:0]           pattern: 0 gradient, 1 colour bars, 2 checker, 3 solid
//   solid_rgb           {R,G,B} colour used in solid mode
//   Red/Green/Blue      pixel colour (zero while blanked)
//   hSync/vSync         sync outputs
//   blank               high outside the visible area
//   hPos/vPos           position of the pixel currently on the outputs
//   frameStart          one-cycle pulse with pixel (0,0)
//   lineStart           one-cycle pulse at hPos==0 on every line
// -----------------------------------------------------------------------------
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = VGA_640x480.h_active,
    parameter int   H_FP       = VGA_640x480.h_fp,
    parameter int   H_SYNC     = VGA_640x480.h_sync,
    parameter int   H_BP       = VGA_640x480.h_bp,
    parameter int   V_ACTIVE   = VGA_640x480.v_active,
    parameter int   V_FP       = VGA_640x480.v_fp,
    parameter int   V_SYNC     = VGA_640x480.v_sync,
    parameter int   V_BP       = VGA_640x480.v_bp,
    parameter logic H_SYNC_POL = VGA_640x480.h_pol,
    parameter logic V_SYNC_POL = VGA_640x480.v_pol,
    parameter int   CNT_W      = 12,
    parameter int   COLOR_W    = 8,
    parameter int   BAR_W      = 80,
    parameter int   CHECK_LOG2 = 5
) (
    input  logic                 pixelClock,
    input  logic                 reset,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic [COLOR_W-1:0]   Red,
    output logic [COLOR_W-1:0]   Green,
    output logic [COLOR_W-1:0]   Blue,
    output logic                 hSync,
    output logic                 vSync,
    output logic                 blank,
    output logic [CNT_W-1:0]     hPos,
    output logic [CNT_W-1:0]     vPos,
    output logic                 frameStart,
    output logic                 lineStart
);

    localparam logic [CNT_W-1:0]   BAR_LAST = CNT_W'(BAR_W - 1);
    localparam logic [COLOR_W-1:0] ONES     = {COLOR_W{1'b1}};

    logic [CNT_W-1:0] w_hCnt, w_vCnt;
    logic             w_active, w_lineEnd, w_frameEnd;

    vga_timing_core #(
        .H_ACTIVE   (H_ACTIVE),
        .H_FP       (H_FP),
        .H_SYNC     (H_SYNC),
        .H_BP       (H_BP),
        .V_ACTIVE   (V_ACTIVE),
        .V_FP       (V_FP),
        .V_SYNC     (V_SYNC),
        .V_BP       (V_BP),
        .H_SYNC_POL (H_SYNC_POL),
        .V_SYNC_POL (V_SYNC_POL),
        .CNT_W      (CNT_W)
    ) u_timing (
        .i_clk        (pixelClock),
        .i_reset      (reset),
        .o_hCnt       (w_hCnt),
        .o_vCnt       (w_vCnt),
        .o_active     (w_active),
        .o_lineEnd    (w_lineEnd),
        .o_frameEnd   (w_frameEnd),
        .o_hSync      (hSync),
        .o_vSync      (vSync),
        .o_blank      (blank),
        .o_hPos       (hPos),
        .o_vPos       (vPos),
        .o_frameStart (frameStart),
        .o_lineStart  (lineStart)
    );

    // Pattern is only sampled on the last pixel of a frame, so a mid-frame
    // change never tears the picture; the new mode starts at pixel (0,0).
    mode_e r_curMode;

    always_ff @(posedge pixelClock) begin
        if (reset || w_frameEnd)
            r_curMode <= mode_e'(mode);
    end

    // Bar counter tracks hCnt: cleared entering hCnt==0, so r_barIdx is
    // min(hCnt / BAR_W, 7) for the pixel the counters currently point at.
    logic [CNT_W-1:0] r_barCnt;
    logic [2:0]       r_barIdx;

    always_ff @(posedge pixelClock) begin
        if (reset || w_lineEnd) begin
            r_barCnt <= '0;
            r_barIdx <= '0;
        end else if (r_barCnt == BAR_LAST) begin
            r_barCnt <= '0;
            if (r_barIdx != 3'd7)
                r_barIdx <= r_barIdx + 3'd1;
        end else begin
            r_barCnt <= r_barCnt + 1'b1;
        end
    end

    logic [COLOR_W-1:0] w_red, w_grn, w_blu;

    always_comb begin
        w_red = '0;
        w_grn = '0;
        w_blu = '0;
        if (w_active) begin
            case (r_curMode)
                MODE_GRADIENT: begin
                    w_red = COLOR_W'(w_hCnt);
                    w_grn = COLOR_W'(w_vCnt);
                    w_blu = COLOR_W'(w_hCnt + w_vCnt);
                end
                MODE_BARS: begin
                    // Index bits map to inverted channels: white, yellow,
                    // cyan, green, magenta, red, blue, black.
                    w_red = r_barIdx[1] ? '0 : ONES;
                    w_grn = r_barIdx[2] ? '0 : ONES;
                    w_blu = r_barIdx[0] ? '0 : ONES;
                end
                MODE_CHECK: begin
                    if (w_hCnt[CHECK_LOG2] ^ w_vCnt[CHECK_LOG2]) begin
                        w_red = ONES;
                        w_grn = ONES;
                        w_blu = ONES;
                    end
                end
                MODE_SOLID: begin
                    {w_red, w_grn, w_blu} = solid_rgb;
                end
                default: ;
            endcase
        end
    end

    logic [COLOR_W-1:0] r_red, r_grn, r_blu;

    always_ff @(posedge pixelClock) begin
        if (reset) begin
            r_red <= '0;
            r_grn <= '0;
            r_blu <= '0;
        end else begin
            r_red <= w_red;
            r_grn <= w_grn;
            r_blu <= w_blu;
        end
    end

    assign Red   = r_red;
    assign Green = r_grn;
    assign Blue  = r_blu;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_pattern_gen
// Small-mode bench (16x8 total, 8x4 visible). A reference model tracks the
// displayed pixel as a linear index into the frame and derives every output
// from the display rules; a checker compares the DUT against it every cycle.
// -----------------------------------------------------------------------------
module tb_vga_pattern_gen;

    localparam int HA = 8, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;
    localparam int CW = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [23:0] solid = 24'h0;

    logic [7:0]    Red, Green, Blue;
    logic          hSync, vSync, blank, frameStart, lineStart;
    logic [CW-1:0] hPos, vPos;

    always #5 clk = ~clk;

    vga_pattern_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .H_SYNC_POL (1'b0), .V_SYNC_POL (1'b0),
        .CNT_W (CW), .COLOR_W (8), .BAR_W (1), .CHECK_LOG2 (1)
    ) dut (
        .pixelClock (clk),
        .reset      (reset),
        .mode       (mode),
        .solid_rgb  (solid),
        .Red        (Red),
        .Green      (Green),
        .Blue       (Blue),
        .hSync      (hSync),
        .vSync      (vSync),
        .blank      (blank),
        .hPos       (hPos),
        .vPos       (vPos),
        .frameStart (frameStart),
        .lineStart  (lineStart)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Colour-bar table, left to right.
    logic [23:0] bars [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // Expected {R,G,B,hSync,vSync,blank} for linear frame index p.
    function automatic logic [26:0] exp_vid(int p, logic [1:0] md, logic [23:0] s);
        int h, v;
        logic act, hs_n, vs_n;
        logic [23:0] rgb;
        h    = p % HT;
        v    = p / HT;
        act  = (h < HA) && (v < VA);
        hs_n = !((h >= HA + HFP) && (h < HA + HFP + HS));
        vs_n = !((v >= VA + VFP) && (v < VA + VFP + VS));
        rgb  = 24'h0;
        if (act) begin
            case (md)
                2'd0: rgb = {8'(h), 8'(v), 8'(h + v)};
                2'd1: rgb = bars[(h > 7) ? 7 : h];
                2'd2: rgb = (((h / 2) % 2) != ((v / 2) % 2)) ? 24'hFFFFFF : 24'h0;
                default: rgb = s;
            endcase
        end
        return {rgb, hs_n, vs_n, !act};
    endfunction

    // Reference model: which frame pixel is shown, with which pattern.
    logic        m_valid = 1'b0;
    int          m_idx = 0;
    int          m_out = 0;
    logic [1:0]  m_cur = 2'd0;
    logic [1:0]  m_outMode = 2'd0;
    logic [23:0] m_outSolid = 24'h0;

    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_idx   <= 0;
            m_cur   <= mode;
        end else begin
            m_valid    <= 1'b1;
            m_out      <= m_idx;
            m_outMode  <= m_cur;
            m_outSolid <= solid;
            m_idx      <= (m_idx + 1) % FT;
            if (m_idx == FT - 1)
                m_cur <= mode;
        end
    end

    int          cyc = 0;
    int          last_fs = -1;
    int          last_ls = -1;
    logic [26:0] e_vid;
    logic [23:0] e_pos;
    logic [1:0]  e_str;

    always @(negedge clk) begin
        cyc++;
        if (m_valid) begin
            e_vid = exp_vid(m_out, m_outMode, m_outSolid);
            e_pos = {12'(m_out % HT), 12'(m_out / HT)};
            e_str = {m_out == 0, (m_out % HT) == 0};
        end else begin
            e_vid = {24'h0, 1'b1, 1'b1, 1'b1};
            e_pos = 24'h0;
            e_str = 2'b00;
            last_fs = -1;
            last_ls = -1;
        end
        chk("video", 64'({Red, Green, Blue, hSync, vSync, blank}), 64'(e_vid));
        chk("pos", 64'({hPos, vPos}), 64'(e_pos));
        chk("strobe", 64'({frameStart, lineStart}), 64'(e_str));
        if (frameStart) begin
            if (last_fs >= 0) chk("fs_period", 64'(cyc - last_fs), 64'(FT));
            last_fs = cyc;
        end
        if (lineStart) begin
            if (last_ls >= 0) chk("ls_period", 64'(cyc - last_ls), 64'(HT));
            last_ls = cyc;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pos(input int h, input int v);
        int   k;
        logic found;
        k = 0;
        found = 1'b0;
        while (!found && k < 2 * FT) begin
            @(negedge clk);
            found = (hPos == CW'(h)) && (vPos == CW'(v)) && m_valid;
            k++;
        end
        chk("wait_pos", 64'(found), 64'(1));
    endtask

    initial begin
        reset = 1'b1;
        mode  = 2'd0;
        solid = 24'h0;
        cycles(3);
        reset = 1'b0;
        cycles(2 * FT);

        // Gradient -> solid mid-frame; takes effect at the next frame.
        wait_pos(0, 2);
        mode  = 2'd3;
        solid = 24'h123456;
        cycles(2 * FT);

        mode = 2'd1;
        cycles(2 * FT + 20);
        mode = 2'd2;
        cycles(2 * FT);

        // Reset mid-frame.
        wait_pos(5, 2);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(FT + 40);

        repeat (25) begin
            mode  = 2'($urandom_range(0, 3));
            solid = 24'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                cycles(int'($urandom_range(1, 3)));
                reset = 1'b0;
            end
            cycles(int'($urandom_range(1, 300)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
